seq_booth_multiplier: RTL and testbench

- Iterative radix-2 Booth multiplier, parametrised successor of the combinational Booth array.
- Performs one Booth step per clock. Per-operand signed/unsigned mode is captured with each operation.
- Input and output use valid/ready handshakes; sits between an operand-issue stage and a result consumer in the datapath.
- Trades area for latency: one adder of width m_size+2 instead of r_size unrolled stages.

---
 rtl/seq_booth_multiplier.sv | 90 +++++++++
 tb/tb_seq_booth_multiplier.sv | 118 +++++++++++
 2 files changed

// File: rtl/seq_booth_multiplier.sv
// Iterative radix-2 Booth multiplier with one Booth step per clock.
// Valid/ready on both sides; each operand is signed or unsigned per operation.
module seq_booth_multiplier #(
  parameter int m_size = 8,
  parameter int r_size = 8,
  localparam int res_size = m_size + r_size
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [m_size-1:0]   M,
  input  logic [r_size-1:0]   R,
  input  logic                m_signed,
  input  logic                r_signed,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [res_size-1:0] RES,
  output logic                busy
);

  localparam int W  = m_size + r_size + 3;
  localparam int CW = $clog2(r_size + 2);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [W-1:0]      p, p_step;
  logic [m_size:0]   a, s, me, addend;
  logic [r_size:0]   re;
  logic [m_size+1:0] sum;
  logic [CW-1:0]     cnt;
  logic              accept, last_step;

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN);
  assign accept    = in_valid && in_ready;
  assign last_step = (cnt == CW'(1));

  assign me = m_signed ? {M[m_size-1], M} : {1'b0, M};
  assign re = r_signed ? {R[r_size-1], R} : {1'b0, R};

  // Upper field is summed one bit wider so the arithmetic shift keeps the true sign.
  always_comb begin
    addend = '0;
    case (p[1:0])
      2'b01:   addend = a;
      2'b10:   addend = s;
      default: addend = '0;
    endcase
    sum    = {p[W-1], p[W-1:r_size+2]} + {addend[m_size], addend};
    p_step = {sum, p[r_size+1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = in_valid ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p   <= '0;
      a   <= '0;
      s   <= '0;
      cnt <= '0;
      RES <= '0;
    end else if (accept) begin
      p   <= {{(m_size+1){1'b0}}, re, 1'b0};
      a   <= me;
      s   <= -me;
      cnt <= CW'(r_size + 1);
    end else if (state == RUN) begin
      p   <= p_step;
      cnt <= cnt - CW'(1);
      if (last_step) RES <= p_step[res_size:1];
    end
  end

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Directed bench for seq_booth_multiplier: default 8x8 instance plus an 8x4 instance.
module tb_seq_booth_multiplier;

  logic clk = 0, rst = 1;
  always #5 clk = ~clk;

  logic        iv0 = 0, ir0, ms0 = 0, rs0 = 0, ov0, or0 = 1, busy0;
  logic [7:0]  m0 = 0, r0 = 0;
  logic [15:0] res0;

  logic        iv1 = 0, ir1, ms1 = 0, rs1 = 0, ov1, or1 = 1, busy1;
  logic [7:0]  m1 = 0;
  logic [3:0]  r1 = 0;
  logic [11:0] res1;

  int tests = 0, fails = 0;

  seq_booth_multiplier dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .M(m0), .R(r0),
    .m_signed(ms0), .r_signed(rs0), .out_valid(ov0), .out_ready(or0),
    .RES(res0), .busy(busy0));

  seq_booth_multiplier #(.m_size(8), .r_size(4)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .M(m1), .R(r1),
    .m_signed(ms1), .r_signed(rs1), .out_valid(ov1), .out_ready(or1),
    .RES(res1), .busy(busy1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents one operation, returns 1 time unit after the accepting edge.
  task automatic launch(input bit sel, input logic [7:0] m, input logic [7:0] r,
                        input bit ms, input bit rs);
    if (!sel) begin m0 = m; r0 = r; ms0 = ms; rs0 = rs; iv0 = 1; end
    else begin m1 = m; r1 = r[3:0]; ms1 = ms; rs1 = rs; iv1 = 1; end
    @(posedge clk); #1;
    iv0 = 0; iv1 = 0;
  endtask

  task automatic wait_res(input bit sel, input int lat, input logic [15:0] exp, input string tag);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(sel ? ov1 : ov0) && n < 40);
    check({tag, " latency"}, n, lat);
    check({tag, " result"}, sel ? {20'd0, res1} : {16'd0, res0}, {16'd0, exp});
  endtask

  task automatic op(input bit sel, input logic [7:0] m, input logic [7:0] r,
                    input bit ms, input bit rs, input logic [15:0] exp, input string tag);
    launch(sel, m, r, ms, rs);
    wait_res(sel, sel ? 5 : 9, exp, tag);
    @(posedge clk); #1;
  endtask

  initial begin
    #2;
    check("reset in_ready", ir0, 1);
    check("reset out_valid", ov0, 0);
    check("reset busy", busy0, 0);
    check("reset RES", res0, 0);
    @(posedge clk); #1 rst = 0;

    launch(0, 8'hFF, 8'hFF, 0, 0);
    check("uu busy", busy0, 1);
    check("uu in_ready", ir0, 0);
    wait_res(0, 9, 16'hFE01, "uu FFxFF");
    @(posedge clk); #1;
    check("retire out_valid", ov0, 0);
    check("retire RES kept", res0, 16'hFE01);

    op(0, 8'h80, 8'h80, 1, 1, 16'h4000, "ss 80x80");
    op(0, 8'hFF, 8'h7F, 1, 1, 16'hFF81, "ss -1x127");
    op(0, 8'hFE, 8'hFF, 1, 0, 16'hFE02, "su -2x255");
    op(0, 8'hFE, 8'hFF, 0, 0, 16'hFD02, "uu FExFF");

    or0 = 0;
    launch(0, 8'd3, 8'd5, 0, 0);
    wait_res(0, 9, 16'h000F, "bp 3x5");
    repeat (20) @(posedge clk);
    #1;
    check("bp out_valid held", ov0, 1);
    check("bp RES held", res0, 16'h000F);
    check("bp in_ready", ir0, 0);
    or0 = 1; m0 = 8'd7; r0 = 8'd9; ms0 = 0; rs0 = 0; iv0 = 1;
    #1 check("same-edge in_ready", ir0, 1);
    @(posedge clk); #1 iv0 = 0;
    check("same-edge out_valid", ov0, 0);
    check("same-edge busy", busy0, 1);
    wait_res(0, 9, 16'h003F, "b2b 7x9");
    @(posedge clk); #1;

    launch(0, 8'd100, 8'd100, 0, 0);
    repeat (4) @(posedge clk);
    #1 rst = 1;
    #1;
    check("midrst out_valid", ov0, 0);
    check("midrst in_ready", ir0, 1);
    check("midrst RES", res0, 0);
    check("midrst busy", busy0, 0);
    @(posedge clk); #1 rst = 0;
    op(0, 8'd2, 8'd3, 0, 0, 16'h0006, "post-rst 2x3");

    op(1, 8'h80, 8'h08, 1, 1, 16'h0400, "r4 ss -128x-8");
    op(1, 8'hFF, 8'h0F, 0, 0, 16'h0EF1, "r4 uu 255x15");
    op(1, 8'h81, 8'h07, 1, 0, 16'h0C87, "r4 su -127x7");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
